// File: rtl/ins_align_buffer.sv
// Halfword-granular instruction realignment buffer between fetch and decode.
// RV_ALIGN_RVC_EN enables 16-bit (RVC) instructions; without it every instruction is 32-bit.
module ins_align_buffer #(
  parameter int C_DEPTH_HW = 8,
  parameter int C_XLEN     = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [31:0]       fetch_data_i,
  input  logic [C_XLEN-1:0] fetch_addr_i,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  output logic [31:0]       ins_o,
  output logic [1:0]        ins_size_o,
  output logic [C_XLEN-1:0] ins_pc_o,
  output logic              ins_err_o
);

  localparam int PW = $clog2(C_DEPTH_HW);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(C_DEPTH_HW);

  typedef logic [PW-1:0] ptr_t;

  logic [15:0]       hw_buf_q [C_DEPTH_HW];
  logic [15:0]       hw_buf_d [C_DEPTH_HW];
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pc_valid_q, pc_valid_d;
  logic [C_XLEN-1:0] pc_head_q, pc_head_d;

  logic [15:0]       h0, h1;
  logic              is32;
  logic              head_valid, head_32, head_err;
  logic              need_two;
  logic [CW-1:0]     free_hw, need_hw;
  logic              push, pop;
  logic [CW-1:0]     push_cnt, pop_cnt;
  logic [C_XLEN-1:0] pc_load;
  logic              unused_addr;

  assign unused_addr = ^fetch_addr_i[1:0];

  assign h0   = hw_buf_q[rd_ptr_q];
  assign h1   = hw_buf_q[rd_ptr_q + ptr_t'(1)];
  assign is32 = (h0[1:0] == 2'b11);

`ifdef RV_ALIGN_RVC_EN
  assign head_32    = is32;
  assign head_valid = is32 ? (count_q >= CW'(2)) : (count_q >= CW'(1));
  assign head_err   = 1'b0;
  // Only the very first word after reset/flush may start on the upper halfword.
  assign need_two   = !(!pc_valid_q && fetch_addr_i[1]);
  assign pc_load    = {fetch_addr_i[C_XLEN-1:1], 1'b0};
`else
  assign head_32    = 1'b1;
  assign head_valid = (count_q >= CW'(2));
  assign head_err   = !is32;
  assign need_two   = 1'b1;
  assign pc_load    = {fetch_addr_i[C_XLEN-1:2], 2'b00};
`endif

  assign free_hw       = DEPTH - count_q;
  assign need_hw       = need_two ? CW'(2) : CW'(1);
  assign fetch_ready_o = !reset_i && !flush_i && (free_hw >= need_hw);

  assign push     = fetch_valid_i && fetch_ready_o;
  assign pop      = head_valid && ins_ready_i && !flush_i;
  assign push_cnt = push ? need_hw : CW'(0);
  assign pop_cnt  = pop ? (head_32 ? CW'(2) : CW'(1)) : CW'(0);

  assign ins_valid_o = head_valid;
  assign ins_o       = !head_valid ? 32'h0 : (head_32 ? {h1, h0} : {16'h0, h0});
  assign ins_size_o  = (head_valid && !head_32) ? 2'b01 : 2'b10;
  assign ins_pc_o    = pc_head_q;
  assign ins_err_o   = head_valid && head_err;

  always_comb begin
    hw_buf_d   = hw_buf_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_valid_d = pc_valid_q;
    pc_head_d  = pc_head_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      pc_valid_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + ptr_t'(pop_cnt);
        pc_head_d = pc_head_q + (head_32 ? C_XLEN'(4) : C_XLEN'(2));
      end
      if (push) begin
        if (need_two) begin
          hw_buf_d[wr_ptr_q]              = fetch_data_i[15:0];
          hw_buf_d[wr_ptr_q + ptr_t'(1)]  = fetch_data_i[31:16];
          wr_ptr_d                        = wr_ptr_q + ptr_t'(2);
        end else begin
          hw_buf_d[wr_ptr_q] = fetch_data_i[31:16];
          wr_ptr_d           = wr_ptr_q + ptr_t'(1);
        end
        // A non-empty buffer implies pc_valid, so this never collides with a pop.
        if (!pc_valid_q) begin
          pc_head_d  = pc_load;
          pc_valid_d = 1'b1;
        end
      end
      count_d = count_q + push_cnt - pop_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_valid_q <= 1'b0;
      pc_head_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_valid_q <= pc_valid_d;
      pc_head_q  <= pc_head_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    hw_buf_q <= hw_buf_d;
  end

endmodule

// File: tb/tb_ins_align_buffer.sv
// Randomized bench for ins_align_buffer against a halfword-queue reference model.
// Honours RV_ALIGN_RVC_EN the same way as the design.
module tb_ins_align_buffer;

  localparam int D = 8;
`ifdef RV_ALIGN_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i = '0;
  logic [31:0] fetch_addr_i = '0;
  logic        ins_valid_o;
  logic        ins_ready_i = 1'b0;
  logic [31:0] ins_o;
  logic [1:0]  ins_size_o;
  logic [31:0] ins_pc_o;
  logic        ins_err_o;

  ins_align_buffer #(.C_DEPTH_HW(D), .C_XLEN(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_data_i(fetch_data_i), .fetch_addr_i(fetch_addr_i),
    .ins_valid_o(ins_valid_o), .ins_ready_i(ins_ready_i),
    .ins_o(ins_o), .ins_size_o(ins_size_o), .ins_pc_o(ins_pc_o),
    .ins_err_o(ins_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the buffered halfwords in arrival order plus the head PC.
  logic [15:0] mq[$];
  logic [31:0] m_pc = '0;
  bit          m_pcv = 1'b0;
  bit          obs_ready;
  bit          last_acc;

  task automatic model_head(output bit v, output logic [31:0] ins, output logic [1:0] sz,
                            output bit err);
    v = 1'b0; ins = '0; sz = 2'b10; err = 1'b0;
    if (RVC) begin
      if (mq.size() >= 1) begin
        if (mq[0][1:0] == 2'b11) begin
          if (mq.size() >= 2) begin
            v = 1'b1; ins = {mq[1], mq[0]};
          end
        end else begin
          v = 1'b1; ins = {16'h0, mq[0]}; sz = 2'b01;
        end
      end
    end else if (mq.size() >= 2) begin
      v = 1'b1; ins = {mq[1], mq[0]}; err = (mq[0][1:0] != 2'b11);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle, advance the model, return at posedge+1.
  task automatic cyc(input bit fv, input logic [31:0] fd, input logic [31:0] fa,
                     input bit ir, input bit fl);
    int          need;
    bit          e_rdy, ev, eerr;
    logic [31:0] eins;
    logic [1:0]  esz;
    fetch_valid_i = fv; fetch_data_i = fd; fetch_addr_i = fa;
    ins_ready_i = ir; flush_i = fl;
    #4;
    need  = (RVC && !m_pcv && fa[1]) ? 1 : 2;
    e_rdy = !fl && ((D - mq.size()) >= need);
    model_head(ev, eins, esz, eerr);
    obs_ready = fetch_ready_o;
    check("fetch_ready", fetch_ready_o, e_rdy);
    check("ins_valid", ins_valid_o, ev);
    if (ev) begin
      check("ins", ins_o, eins);
      check("ins_size", ins_size_o, esz);
      check("ins_pc", ins_pc_o, m_pc);
      check("ins_err", ins_err_o, eerr);
    end
    if (ev && ir && !fl) begin
      void'(mq.pop_front());
      if (esz == 2'b10) void'(mq.pop_front());
      m_pc = m_pc + ((esz == 2'b10) ? 32'd4 : 32'd2);
    end
    last_acc = e_rdy && fv;
    if (fl) begin
      mq.delete(); m_pcv = 1'b0;
    end else if (last_acc) begin
      if (!m_pcv) begin
        m_pc  = RVC ? {fa[31:1], 1'b0} : {fa[31:2], 2'b00};
        m_pcv = 1'b1;
      end
      if (need == 1) mq.push_back(fd[31:16]);
      else begin
        mq.push_back(fd[15:0]); mq.push_back(fd[31:16]);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; fetch_valid_i = 1'b0; ins_ready_i = 1'b0; flush_i = 1'b0;
    #1;
    mq.delete(); m_pcv = 1'b0; m_pc = '0;
    check("rst_ready", fetch_ready_o, 0);
    check("rst_valid", ins_valid_o, 0);
    check("rst_ins", ins_o, 0);
    check("rst_size", ins_size_o, 2'b10);
    check("rst_pc", ins_pc_o, 0);
    check("rst_err", ins_err_o, 0);
    @(posedge clk_i); #1;
    check("rst_hold_ready", fetch_ready_o, 0);
    reset_i = 1'b0;
    #1;
    check("rst_rel_ready", fetch_ready_o, 1);
    @(posedge clk_i); #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] d;
    d = $urandom;
    if ($urandom_range(0, 1) == 1) d[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) d[17:16] = 2'b11;
    return d;
  endfunction

  initial begin
    int          acc_dut;
    int          acc_m;
    logic [31:0] cur_addr;
    int          r;

    #2;
    do_reset();

    // Aligned 32-bit instruction appears the cycle after acceptance.
    cyc(1, 32'h00A00093, 32'h100, 1, 0);
    check("al_ins", ins_o, 32'h00A00093);
    check("al_size", ins_size_o, 2'b10);
    check("al_pc", ins_pc_o, 32'h100);
    cyc(0, 0, 0, 1, 0);

    // Mixed stream.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h00930505, 32'h200, 0, 0);
    cyc(1, 32'h0000000A, 32'h204, 0, 0);
`ifdef RV_ALIGN_RVC_EN
    check("mix0_ins", ins_o, 32'h00000505);
    check("mix0_size", ins_size_o, 2'b01);
    check("mix0_pc", ins_pc_o, 32'h200);
    cyc(0, 0, 0, 1, 0);
    check("mix1_ins", ins_o, 32'h000A0093);
    check("mix1_size", ins_size_o, 2'b10);
    check("mix1_pc", ins_pc_o, 32'h202);
`else
    check("mix0_ins", ins_o, 32'h00930505);
    check("mix0_err", ins_err_o, 1);
    check("mix0_pc", ins_pc_o, 32'h200);
    cyc(0, 0, 0, 1, 0);
    check("mix1_ins", ins_o, 32'h0000000A);
    check("mix1_err", ins_err_o, 1);
    check("mix1_pc", ins_pc_o, 32'h204);
`endif
    cyc(0, 0, 0, 1, 0);

    // Halfword-aligned start after flush.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h4501BEEF, 32'h302, 0, 0);
`ifdef RV_ALIGN_RVC_EN
    check("hw_ins", ins_o, 32'h00004501);
    check("hw_size", ins_size_o, 2'b01);
    check("hw_pc", ins_pc_o, 32'h302);
`else
    check("hw_ins", ins_o, 32'h4501BEEF);
    check("hw_err", ins_err_o, 0);
    check("hw_pc", ins_pc_o, 32'h300);
`endif

    // Fill to full with decode stalled, then drain while still pushing across the wrap.
    cyc(0, 0, 0, 0, 1);
    acc_dut = 0; acc_m = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, {16'(16'hA000 + acc_m), 16'(16'h0003 + (acc_m << 8))}, 32'h1000 + 32'(4 * acc_m), 0, 0);
      acc_dut += int'(obs_ready);
      acc_m += int'(last_acc);
    end
    check("full_acc", acc_dut, 4);
    check("full_ready", fetch_ready_o, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, {16'(16'hA000 + acc_m), 16'(16'h0003 + (acc_m << 8))}, 32'h1000 + 32'(4 * acc_m), 1, 0);
      acc_m += int'(last_acc);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
    check("drain_valid", ins_valid_o, 0);

    // Flush while data is pending and a fetch is offered.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h00A00093, 32'h100, 0, 0);
    cyc(1, 32'h12345677, 32'h500, 1, 1);
    check("fl_valid", ins_valid_o, 0);
    cyc(1, 32'h00100073, 32'h400, 0, 0);
    check("fl_pc", ins_pc_o, 32'h400);
    check("fl_ins", ins_o, 32'h00100073);

    // Reset mid-stream with a partly filled buffer.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h4501BEEF, 32'h302, 0, 0);
    cyc(1, 32'h00A00093, 32'h304, 0, 0);
    cyc(1, 32'h00B00113, 32'h308, 0, 0);
    do_reset();

    // Random traffic.
    cur_addr = 32'h2000;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 4) begin
        cyc($urandom_range(0, 1) == 1, rand_word(), cur_addr, $urandom_range(0, 1) == 1, 1);
        cur_addr = $urandom & 32'hFFFF_FFFE;
      end else if (r == 4) begin
        do_reset();
        cur_addr = $urandom & 32'hFFFF_FFFE;
      end else begin
        cyc($urandom_range(0, 9) < 7, rand_word(), cur_addr, $urandom_range(0, 9) < 6, 0);
        if (last_acc) cur_addr = (cur_addr & 32'hFFFF_FFFC) + 32'd4;
      end
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
